// File: rtl/mux_nx1_seq.sv
// N-channel registered multiplexer: manual per-word select, or scan mode that
// captures every channel and serialises them one per cycle with a channel tag.
module mux_nx1_seq #(
   parameter int DATA_WIDTH = 10,
   parameter int N_CH       = 3,
   parameter int SEL_W      = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [N_CH*DATA_WIDTH-1:0] i_din,
   input  logic                       i_din_valid,
   output logic                       o_din_ready,
   input  logic                       i_mode,
   input  logic [SEL_W-1:0]           i_sel,
   input  logic                       i_hold,
   output logic [DATA_WIDTH-1:0]      o_mux_out,
   output logic                       o_out_valid,
   output logic [SEL_W-1:0]           o_ch_out,
   output logic                       o_frame_start,
   output logic                       o_sel_err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   state_t                r_state, w_state_nxt;
   logic [SEL_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [DATA_WIDTH-1:0] r_buf [N_CH];
   logic [DATA_WIDTH-1:0] w_din_ch [N_CH];
   logic [DATA_WIDTH-1:0] r_mux_out, w_mux_out_nxt;
   logic [SEL_W-1:0]      r_ch_out, w_ch_out_nxt;
   logic                  r_out_valid, w_out_valid_nxt;
   logic                  r_frame_start, w_frame_start_nxt;
   logic                  r_sel_err, w_sel_err_nxt;
   logic [DATA_WIDTH-1:0] w_sel_data, w_scan_data;
   logic                  w_sel_ok, w_last, w_accept, w_capture, w_ready;

   assign w_last    = (r_cnt == LAST_CH);
   assign w_cnt_inc = r_cnt + SEL_W'(1);
   assign w_sel_ok  = (i_sel <= LAST_CH);
   assign w_accept  = i_din_valid & w_ready;

   // Unpack channels and pick the manual / next-scan samples without out-of-range indexing.
   always_comb begin
      w_sel_data  = {DATA_WIDTH{1'b0}};
      w_scan_data = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         w_din_ch[k] = i_din[k*DATA_WIDTH +: DATA_WIDTH];
         w_sel_data  = (i_sel == SEL_W'(k)) ? w_din_ch[k] : w_sel_data;
         w_scan_data = (w_cnt_inc == SEL_W'(k)) ? r_buf[k] : w_scan_data;
      end
   end

   // Ready: idle and not stalled, or showing the last channel of a frame.
   always_comb begin
      w_ready = 1'b0;
      if (!i_rst_n || i_hold) begin
         w_ready = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_SCAN: w_ready = w_last;
            default: w_ready = 1'b0;
         endcase
      end
   end

   // Next-state and next-output logic; hold leaves every register untouched.
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_mux_out_nxt     = r_mux_out;
      w_ch_out_nxt      = r_ch_out;
      w_out_valid_nxt   = r_out_valid;
      w_frame_start_nxt = r_frame_start;
      w_sel_err_nxt     = r_sel_err;
      w_capture         = 1'b0;
      if (w_accept) begin
         w_out_valid_nxt   = 1'b1;
         w_cnt_nxt         = {SEL_W{1'b0}};
         w_frame_start_nxt = i_mode;
         w_capture         = i_mode;
         if (i_mode) begin
            w_state_nxt   = ST_SCAN;
            w_mux_out_nxt = w_din_ch[0];
            w_ch_out_nxt  = {SEL_W{1'b0}};
            w_sel_err_nxt = 1'b0;
         end else begin
            w_state_nxt   = ST_IDLE;
            w_mux_out_nxt = w_sel_ok ? w_sel_data : {DATA_WIDTH{1'b0}};
            w_ch_out_nxt  = i_sel;
            w_sel_err_nxt = ~w_sel_ok;
         end
      end else if (!i_hold && (r_state == ST_SCAN) && !w_last) begin
         w_cnt_nxt         = w_cnt_inc;
         w_mux_out_nxt     = w_scan_data;
         w_ch_out_nxt      = w_cnt_inc;
         w_out_valid_nxt   = 1'b1;
         w_frame_start_nxt = 1'b0;
         w_sel_err_nxt     = 1'b0;
      end else if (!i_hold) begin
         w_state_nxt       = ST_IDLE;
         w_out_valid_nxt   = 1'b0;
         w_frame_start_nxt = 1'b0;
         w_sel_err_nxt     = 1'b0;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // State, counter, capture buffer and output registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= {SEL_W{1'b0}};
         r_mux_out     <= {DATA_WIDTH{1'b0}};
         r_ch_out      <= {SEL_W{1'b0}};
         r_out_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_sel_err     <= 1'b0;
         for (int k = 0; k < N_CH; k++) begin
            r_buf[k] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_mux_out     <= w_mux_out_nxt;
         r_ch_out      <= w_ch_out_nxt;
         r_out_valid   <= w_out_valid_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_sel_err     <= w_sel_err_nxt;
         for (int k = 0; k < N_CH; k++) begin
            if (w_capture) begin
               r_buf[k] <= w_din_ch[k];
            end else begin
               r_buf[k] <= r_buf[k];
            end
         end
      end
   end

   // A stalled cycle never presents a valid sample; the frozen sample reappears once hold falls.
   assign o_din_ready   = w_ready;
   assign o_mux_out     = r_mux_out;
   assign o_ch_out      = r_ch_out;
   assign o_out_valid   = r_out_valid & ~i_hold;
   assign o_frame_start = r_frame_start & ~i_hold;
   assign o_sel_err     = r_sel_err & ~i_hold;

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Self-checking bench for mux_nx1_seq: directed plan steps plus random traffic,
// checked every cycle against a queue-based model of pending scan samples.
module tb_mux_nx1_seq;

   localparam int DW = 10;
   localparam int NC = 3;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst_n, din_valid, mode, hold;
   logic [NC*DW-1:0]  din;
   logic [SW-1:0]     sel;
   logic              din_ready, out_valid, frame_start, sel_err;
   logic [DW-1:0]     mux_out;
   logic [SW-1:0]     ch_out;

   int passes = 0;
   int total  = 0;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] ch;
      logic          fs;
      logic          err;
   } item_t;

   item_t q[$];
   item_t cur;
   bit    shown;

   mux_nx1_seq #(.DATA_WIDTH(DW), .N_CH(NC), .SEL_W(SW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_din_valid(din_valid),
      .o_din_ready(din_ready), .i_mode(mode), .i_sel(sel), .i_hold(hold),
      .o_mux_out(mux_out), .o_out_valid(out_valid), .o_ch_out(ch_out),
      .o_frame_start(frame_start), .o_sel_err(sel_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] chan(input logic [NC*DW-1:0] w, input int k);
      return w[k*DW +: DW];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   // Model: the frame's not-yet-shown samples wait in q; ready means nothing is pending.
   task automatic model_edge();
      if (!rst_n) begin
         q.delete();
         cur   = '0;
         shown = 1'b0;
      end else if (!hold) begin
         if (din_valid && q.size() == 0) begin
            if (mode) begin
               for (int k = 1; k < NC; k++) q.push_back('{chan(din, k), SW'(k), 1'b0, 1'b0});
               cur = '{chan(din, 0), '0, 1'b1, 1'b0};
            end else if (int'(sel) < NC) begin
               cur = '{chan(din, int'(sel)), sel, 1'b0, 1'b0};
            end else begin
               cur = '{'0, sel, 1'b0, 1'b1};
            end
            shown = 1'b1;
         end else if (q.size() > 0) begin
            cur   = q.pop_front();
            shown = 1'b1;
         end else begin
            shown = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      check("din_ready",   32'(din_ready),   32'(rst_n && !hold && q.size() == 0));
      check("mux_out",     32'(mux_out),     32'(cur.data));
      check("ch_out",      32'(ch_out),      32'(cur.ch));
      check("out_valid",   32'(out_valid),   32'(shown && !hold));
      check("frame_start", 32'(frame_start), 32'(shown && cur.fs && !hold));
      check("sel_err",     32'(sel_err),     32'(shown && cur.err && !hold));
   endtask

   // Called just after a falling edge with inputs already set for this cycle.
   task automatic tick();
      #1 check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic m, input logic [SW-1:0] s,
                        input logic h, input logic [NC*DW-1:0] d);
      din_valid = v; mode = m; sel = s; hold = h; din = d;
   endtask

   localparam logic [NC*DW-1:0] W_MAN  = {10'h3FF, 10'h001, 10'h000};
   localparam logic [NC*DW-1:0] W_SCAN = {10'h2AA, 10'h155, 10'h00F};
   localparam logic [NC*DW-1:0] W_B2B  = {10'h123, 10'h0AB, 10'h3C0};

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 2'd0, 1'b0, W_MAN);
      cur = '0; shown = 1'b0;
      @(posedge clk);
      @(negedge clk);
      repeat (3) tick();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0, W_MAN);
      tick();
      // manual select sel=1, sel=2, out-of-range sel=3
      drive(1'b1, 1'b0, 2'd1, 1'b0, W_MAN); tick();
      drive(1'b0, 1'b0, 2'd1, 1'b0, W_MAN); tick(); tick();
      check("man_sel1_data", 32'(cur.data), 32'h001);
      drive(1'b1, 1'b0, 2'd2, 1'b0, W_MAN); tick();
      drive(1'b0, 1'b0, 2'd2, 1'b0, W_MAN); tick(); tick();
      drive(1'b1, 1'b0, 2'd3, 1'b0, W_MAN); tick();
      drive(1'b0, 1'b0, 2'd3, 1'b0, W_MAN); tick(); tick();
      // single scan frame
      drive(1'b1, 1'b1, 2'd0, 1'b0, W_SCAN); tick();
      drive(1'b0, 1'b1, 2'd0, 1'b0, W_SCAN); repeat (4) tick();
      // back-to-back frames with din_valid held
      drive(1'b1, 1'b1, 2'd0, 1'b0, W_SCAN); tick();
      drive(1'b1, 1'b1, 2'd0, 1'b0, W_B2B);  repeat (5) tick();
      drive(1'b0, 1'b1, 2'd0, 1'b0, W_B2B);  repeat (2) tick();
      // hold for two cycles while ch1 is on the output
      drive(1'b1, 1'b1, 2'd0, 1'b0, W_SCAN); tick();
      drive(1'b0, 1'b1, 2'd0, 1'b0, W_SCAN); tick();
      drive(1'b0, 1'b1, 2'd0, 1'b1, W_SCAN); repeat (2) tick();
      drive(1'b0, 1'b1, 2'd0, 1'b0, W_SCAN); repeat (4) tick();
      // reset during ch1, then a fresh frame starts at ch0
      drive(1'b1, 1'b1, 2'd0, 1'b0, W_B2B); tick();
      drive(1'b0, 1'b1, 2'd0, 1'b0, W_B2B); tick();
      rst_n = 1'b0; tick();
      rst_n = 1'b1; tick();
      drive(1'b1, 1'b1, 2'd0, 1'b0, W_SCAN); tick();
      drive(1'b0, 1'b0, 2'd0, 1'b0, W_SCAN); repeat (4) tick();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         drive(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0), (NC*DW)'({$urandom, $urandom}));
         tick();
      end
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/mux_nx1_seq.md
Name: mux_nx1_seq

Overview:
- Parametrised N-channel registered multiplexer for the interpolator datapath; successor to the 3:1 unit-cell mux.
- Manual mode: selects one channel per accepted input word.
- Scan mode: captures all channels at once and serialises them, one per cycle, with a channel tag. This feeds the interpolator's single shared arithmetic path.

Parameters:
DATA_WIDTH, 10, width of each channel sample and of mux_out
N_CH, 3, number of input channels (>=2)
SEL_W, 2, width of sel and ch_out; must satisfy 2**SEL_W >= N_CH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
din  in  N_CH*DATA_WIDTH  packed channels; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
din_valid  in  1  input word valid
din_ready  out  1  block can accept a word this cycle
mode  in  1  0 = manual select, 1 = scan (serialise all channels)
sel  in  SEL_W  channel index, used in manual mode only
hold  in  1  stall: freezes scan sequencing and output
mux_out  out  DATA_WIDTH  registered selected sample
out_valid  out  1  mux_out is valid this cycle
ch_out  out  SEL_W  channel index of current mux_out
frame_start  out  1  high with channel 0 of a scan frame
sel_err  out  1  one-cycle pulse: manual accept with sel >= N_CH

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low: sampled on the rising edge of clk only.
- Reset (rst_n=0 at edge):
  - state=IDLE, channel counter=0, capture buffer cleared.
  - mux_out=0, out_valid=0, ch_out=0, frame_start=0, sel_err=0.
  - din_ready=0 while rst_n=0; din_ready=1 in the first cycle after release.
  - Reset mid-scan aborts the frame; remaining channels are discarded.
- Accept: a word is accepted when din_valid && din_ready at a rising edge. With din_valid=0, state is unchanged and out_valid drops to 0 next cycle (IDLE).
- States: IDLE and SCAN.
- IDLE, mode=0 (manual):
  - din_ready=1.
  - On accept with sel<N_CH: next cycle mux_out=din[sel], ch_out=sel, out_valid=1 for one cycle (latency 1).
  - On accept with sel>=N_CH: mux_out=0, ch_out=sel, out_valid=1, sel_err=1, all for one cycle.
  - hold=1 in IDLE: din_ready=0, outputs hold their previous values, out_valid=0.
- IDLE, mode=1 (scan), on accept:
  - Capture all N_CH channels into the buffer; go to SCAN with counter=0.
  - Next cycle: mux_out=buf[0], ch_out=0, out_valid=1, frame_start=1.
- SCAN:
  - Each cycle with hold=0: emit buf[cnt] and increment cnt. The frame takes exactly N_CH consecutive valid cycles: ch_out = 0,1,...,N_CH-1.
  - frame_start is high only on the channel-0 cycle.
  - hold=1: counter frozen, mux_out/ch_out hold, out_valid=0. The same channel is re-emitted with out_valid=1 in the first cycle after hold falls; no sample is lost or duplicated.
  - din_ready=1 only in the cycle where the last channel (cnt=N_CH-1) is being emitted and hold=0.
    - Accept in that cycle: new buffer captured, next cycle is channel 0 of the new frame. Gap-free back-to-back frames.
    - No accept in that cycle: return to IDLE.
  - din_valid while din_ready=0 has no effect; the upstream source must hold the word.
  - mode and sel are ignored during SCAN. A mode change takes effect only at the next accept from IDLE or at the frame boundary.
- mode is sampled at the accept edge only.
- Buffer: N_CH registers of DATA_WIDTH bits, written only on accept. No arithmetic; width is preserved.

Test Plan:
- Reset release: rst_n=0 for 3 cycles, din_valid=1 held -> all outputs 0 throughout; din_ready=1 in the first cycle after release.
- Manual select: mode=0, din={ch2=10'h3FF, ch1=10'h001, ch0=10'h000}, sel=1, one-cycle valid -> next cycle mux_out=10'h001, ch_out=1, out_valid=1; then out_valid=0. Repeat with sel=2 -> mux_out=10'h3FF.
- Out-of-range: mode=0, sel=3 -> next cycle mux_out=0, ch_out=3, out_valid=1, sel_err=1 for exactly one cycle.
- Scan frame: mode=1, din={ch2=10'h2AA, ch1=10'h155, ch0=10'h00F}, one accept -> three cycles mux_out=00F,155,2AA; ch_out=0,1,2; frame_start on the first only; din_ready=0 for the first two cycles.
- Back-to-back plus hold:
  - Hold din_valid=1 with a new word offered during the last channel -> six consecutive out_valid cycles with no gap.
  - hold=1 for 2 cycles at ch1 -> out_valid=0 for those 2 cycles, then ch1 re-emitted, then ch2.
- Reset mid-scan: rst_n=0 during ch1 of a frame -> next edge all outputs 0, state IDLE; the following accept starts at ch0.
